// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable waveform generators.
// Each channel produces clkout with a programmable high width, low width and
// start delay. It runs either a finite pulse burst or free-running output.
// Live width updates are double-buffered. They take effect only at a
// LOW->HIGH boundary, so no runt pulse is produced.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   en        per-channel level enable
//   t_high    per-channel high width minus one       (channel i at [i*CW +: CW])
//   t_low     per-channel low width minus one
//   t_delay   per-channel low cycles before the first high phase
//   n_pulses  per-channel burst length, 0 = free-running (channel i at [i*PW +: PW])
//   cfg_upd   per-channel strobe capturing t_high/t_low into the shadow
//   clkout    registered waveform, 1 only in HIGH
//   busy      registered, 1 in DELAY/HIGH/LOW
//   done      registered, 1 in DONE
module clkdiv_multi #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 32,
   parameter int unsigned PW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    en,
   input  logic [NCH*CW-1:0] t_high,
   input  logic [NCH*CW-1:0] t_low,
   input  logic [NCH*CW-1:0] t_delay,
   input  logic [NCH*PW-1:0] n_pulses,
   input  logic [NCH-1:0]    cfg_upd,
   output logic [NCH-1:0]    clkout,
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   localparam logic [PW-1:0] PCNT_MAX = '1;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_t        state;
      logic [CW-1:0] cnt;
      logic [CW-1:0] act_high;
      logic [CW-1:0] act_low;
      logic [CW-1:0] act_delay;
      logic [CW-1:0] shd_high;
      logic [CW-1:0] shd_low;
      logic          pend;
      logic [PW-1:0] pcnt;
      logic [PW-1:0] act_np;
      logic          clk_q;
      logic          busy_q;
      logic          done_q;

      logic [CW-1:0] in_high;
      logic [CW-1:0] in_low;
      logic [CW-1:0] in_delay;
      logic [PW-1:0] in_np;
      logic [PW-1:0] pcnt_inc;
      logic          burst_end;

      assign in_high  = t_high[g*CW +: CW];
      assign in_low   = t_low[g*CW +: CW];
      assign in_delay = t_delay[g*CW +: CW];
      assign in_np    = n_pulses[g*PW +: PW];

      // Pulse counter saturates so free-running mode never wraps it.
      assign pcnt_inc  = (pcnt == PCNT_MAX) ? pcnt : pcnt + PW'(1);
      assign burst_end = (act_np != '0) && (pcnt_inc == act_np);

      // Per-channel waveform FSM with registered outputs.
      always_ff @(posedge clk) begin
         if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pcnt      <= '0;
            act_high  <= '0;
            act_low   <= '0;
            act_delay <= '0;
            act_np    <= '0;
            shd_high  <= '0;
            shd_low   <= '0;
            pend      <= 1'b0;
            clk_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
         end else if ((state != S_IDLE) && !en[g]) begin
            // Enable drop aborts from any active state.
            state  <= S_IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            pend   <= 1'b0;
            clk_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (en[g]) begin
                     act_high  <= in_high;
                     act_low   <= in_low;
                     act_delay <= in_delay;
                     act_np    <= in_np;
                     cnt       <= '0;
                     pcnt      <= '0;
                     pend      <= 1'b0;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
                     if (in_delay != '0) begin
                        state <= S_DELAY;
                        clk_q <= 1'b0;
                     end else begin
                        state <= S_HIGH;
                        clk_q <= 1'b1;
                     end
                  end
               end
               S_DELAY: begin
                  // act_delay is nonzero here, so the subtraction cannot wrap.
                  if (cnt >= act_delay - CW'(1)) begin
                     state <= S_HIGH;
                     cnt   <= '0;
                     clk_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_HIGH: begin
                  if (cnt >= act_high) begin
                     state <= S_LOW;
                     cnt   <= '0;
                     clk_q <= 1'b0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_LOW: begin
                  if (cnt >= act_low) begin
                     cnt  <= '0;
                     pcnt <= pcnt_inc;
                     if (burst_end) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end else begin
                        state <= S_HIGH;
                        clk_q <= 1'b1;
                        // Period boundary: commit a pending width update.
                        if (pend) begin
                           act_high <= shd_high;
                           act_low  <= shd_low;
                           pend     <= 1'b0;
                        end
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_DONE: begin
                  state <= S_DONE;
               end
               default: begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  pcnt   <= '0;
                  pend   <= 1'b0;
                  clk_q  <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            endcase

            // Shadow capture comes last so a strobe on the commit edge
            // re-arms the pending flag and waits for the following boundary.
            if (cfg_upd[g] && ((state == S_HIGH) || (state == S_LOW))) begin
               shd_high <= in_high;
               shd_low  <= in_low;
               pend     <= 1'b1;
            end
         end
      end

      assign clkout[g] = clk_q;
      assign busy[g]   = busy_q;
      assign done[g]   = done_q;
   end

endmodule
